// File: rtl/cv32e40x_irq_ctrl.sv
// Interrupt front-end for the controller FSM: synchronises irq lines, latches
// edge-type lines into pending state, masks, prioritises and presents one request.
module cv32e40x_irq_ctrl #(
   parameter int unsigned IRQ_SYNC_STAGES = 2,
   parameter logic [31:0] EDGE_MASK       = 32'h0000_0000,
   parameter logic [31:0] IRQ_VALID_MASK  = 32'hFFFF_0888
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] irq_i,
   input  logic [31:0] mie_i,
   input  logic        mstatus_mie_i,
   input  logic        debug_mode_i,
   input  logic        dcsr_step_i,
   input  logic        dcsr_stepie_i,
   input  logic        irq_ack_i,
   input  logic [4:0]  irq_ack_id_i,
   input  logic [31:0] mip_clr_i,
   output logic [31:0] mip_o,
   output logic        irq_req_ctrl_o,
   output logic [4:0]  irq_id_ctrl_o,
   output logic        irq_wu_ctrl_o
);

   logic [31:0] irq_s;
   logic [31:0] irq_prev_r;
   logic [31:0] pend_r;
   logic [31:0] ack_clr_s;
   logic [31:0] clr_s;
   logic [31:0] rise_s;
   logic [31:0] pend_nxt_s;
   logic [31:0] en_s;

   // Platform lines 31..16 outrank MEI, MSI, MTI (in that order).
   function automatic logic [4:0] irq_prio(input logic [31:0] en);
      logic [4:0] id;
      id = 5'd0;
      if (|en[31:16]) begin
         for (int i = 16; i < 32; i++) begin
            id = en[i] ? 5'(i) : id;
         end
      end else if (en[11]) begin
         id = 5'd11;
      end else if (en[3]) begin
         id = 5'd3;
      end else if (en[7]) begin
         id = 5'd7;
      end else begin
         id = 5'd0;
      end
      return id;
   endfunction

   generate
      if (IRQ_SYNC_STAGES == 0) begin : g_nosync
         assign irq_s = irq_i;
      end else begin : g_sync
         logic [IRQ_SYNC_STAGES-1:0][31:0] sync_r;

         // Metastability synchroniser chain per irq line.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_r <= '0;
            end else begin
               sync_r[0] <= irq_i;
               for (int i = 1; i < int'(IRQ_SYNC_STAGES); i++) begin
                  sync_r[i] <= sync_r[i-1];
               end
            end
         end

         assign irq_s = sync_r[IRQ_SYNC_STAGES-1];
      end
   endgenerate

   // Next pending state: level lines follow the line, edge lines latch rises until cleared.
   always_comb begin
      ack_clr_s = 32'h0000_0000;
      if (irq_ack_i) begin
         ack_clr_s = 32'h0000_0001 << irq_ack_id_i;
      end else begin
         ack_clr_s = 32'h0000_0000;
      end
      clr_s      = mip_clr_i | ack_clr_s;
      rise_s     = irq_s & ~irq_prev_r;
      pend_nxt_s = ((EDGE_MASK & (rise_s | (pend_r & ~clr_s))) | (~EDGE_MASK & irq_s))
                   & IRQ_VALID_MASK;
   end

   // Pending vector and previous synchronised sample for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r     <= 32'h0000_0000;
         irq_prev_r <= 32'h0000_0000;
      end else begin
         pend_r     <= pend_nxt_s;
         irq_prev_r <= irq_s;
      end
   end

   // Wake-up ignores global enable and debug state so WFI can always exit.
   assign en_s           = pend_r & mie_i;
   assign mip_o          = pend_r;
   assign irq_wu_ctrl_o  = |en_s;
   assign irq_req_ctrl_o = (|en_s) & mstatus_mie_i & ~debug_mode_i
                           & ~(dcsr_step_i & ~dcsr_stepie_i);
   assign irq_id_ctrl_o  = irq_prio(en_s);

endmodule

// File: tb/tb_cv32e40x_irq_ctrl.sv
// Self-checking bench for cv32e40x_irq_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a delay-queue reference model.
module tb_cv32e40x_irq_ctrl;

   localparam int          STG   = 2;
   localparam logic [31:0] EDGE  = 32'h4204_0000;   // lines 18, 25, 30 are edge type
   localparam logic [31:0] VALID = 32'hFFFF_0888;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] irq_i = 32'h0;
   logic [31:0] mie_i = 32'h0;
   logic        mstatus_mie_i = 1'b0;
   logic        debug_mode_i = 1'b0;
   logic        dcsr_step_i = 1'b0;
   logic        dcsr_stepie_i = 1'b0;
   logic        irq_ack_i = 1'b0;
   logic [4:0]  irq_ack_id_i = 5'd0;
   logic [31:0] mip_clr_i = 32'h0;
   logic [31:0] mip_o;
   logic        irq_req_ctrl_o;
   logic [4:0]  irq_id_ctrl_o;
   logic        irq_wu_ctrl_o;

   int n_checks = 0;
   int n_errors = 0;
   bit sb_en = 1'b0;

   logic [31:0] hist [4];   // hist[0] = irq_i sampled at the previous edge
   logic [31:0] m_pend;

   cv32e40x_irq_ctrl #(
      .IRQ_SYNC_STAGES (STG),
      .EDGE_MASK       (EDGE),
      .IRQ_VALID_MASK  (VALID)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq_i),
      .mie_i          (mie_i),
      .mstatus_mie_i  (mstatus_mie_i),
      .debug_mode_i   (debug_mode_i),
      .dcsr_step_i    (dcsr_step_i),
      .dcsr_stepie_i  (dcsr_stepie_i),
      .irq_ack_i      (irq_ack_i),
      .irq_ack_id_i   (irq_ack_id_i),
      .mip_clr_i      (mip_clr_i),
      .mip_o          (mip_o),
      .irq_req_ctrl_o (irq_req_ctrl_o),
      .irq_id_ctrl_o  (irq_id_ctrl_o),
      .irq_wu_ctrl_o  (irq_wu_ctrl_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // A line's pending bit reflects what irq_i was STG edges ago (one more edge for the register).
   function automatic logic [31:0] model_next();
      logic [31:0] s [5];
      logic [31:0] em, vm, nxt;
      bit ack_hit;
      em = EDGE;
      vm = VALID;
      s[0] = irq_i;
      for (int j = 0; j < 4; j++) s[j+1] = hist[j];
      for (int i = 0; i < 32; i++) begin
         ack_hit = irq_ack_i && (int'(irq_ack_id_i) == i);
         if (!vm[i])                           nxt[i] = 1'b0;
         else if (!em[i])                      nxt[i] = s[STG][i];
         else if (s[STG][i] && !s[STG+1][i])   nxt[i] = 1'b1;
         else if (mip_clr_i[i] || ack_hit)     nxt[i] = 1'b0;
         else                                  nxt[i] = m_pend[i];
      end
      return nxt;
   endfunction

   function automatic logic [31:0] mdl_en();
      return m_pend & mie_i;
   endfunction

   function automatic logic mdl_req();
      return (mdl_en() != 32'h0) && mstatus_mie_i && !debug_mode_i
             && !(dcsr_step_i && !dcsr_stepie_i);
   endfunction

   function automatic logic [4:0] mdl_id();
      logic [31:0] en;
      int low [3];
      en = mdl_en();
      low = '{11, 3, 7};
      for (int i = 31; i >= 16; i--) if (en[i]) return 5'(i);
      for (int k = 0; k < 3; k++) if (en[low[k]]) return 5'(low[k]);
      return 5'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= 32'h0;
         for (int j = 0; j < 4; j++) hist[j] <= 32'h0;
      end else begin
         m_pend  <= model_next();
         hist[0] <= irq_i;
         for (int j = 1; j < 4; j++) hist[j] <= hist[j-1];
      end
   end

   always @(negedge clk) begin
      if (sb_en) begin
         check("sb_mip", mip_o, m_pend);
         check("sb_req", {31'd0, irq_req_ctrl_o}, {31'd0, mdl_req()});
         check("sb_id",  {27'd0, irq_id_ctrl_o},  {27'd0, mdl_id()});
         check("sb_wu",  {31'd0, irq_wu_ctrl_o},  {31'd0, mdl_en() != 32'h0});
         if (irq_ack_i)
            check("ack_legal", {26'd0, irq_req_ctrl_o, irq_id_ctrl_o},
                  {26'd0, 1'b1, irq_ack_id_i});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      sb_en = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(1);
      check("rst_mip", mip_o, 32'h0);
      check("rst_req", {31'd0, irq_req_ctrl_o}, 32'h0);
      check("rst_id",  {27'd0, irq_id_ctrl_o}, 32'h0);
      check("rst_wu",  {31'd0, irq_wu_ctrl_o}, 32'h0);

      // Level MTI latency
      mie_i = 32'h80; mstatus_mie_i = 1'b1; irq_i = 32'h80;
      step(2);
      check("mti_early", mip_o, 32'h0);
      step(1);
      check("mti_mip", mip_o, 32'h80);
      check("mti_req", {31'd0, irq_req_ctrl_o}, 32'h1);
      check("mti_id",  {27'd0, irq_id_ctrl_o}, 32'd7);
      irq_i = 32'h0;
      step(2);
      check("mti_hold", {31'd0, irq_req_ctrl_o}, 32'h1);
      step(1);
      check("mti_drop", {31'd0, irq_req_ctrl_o}, 32'h0);

      // Priority
      irq_i = 32'h0011_0888; mie_i = 32'hFFFF_FFFF;
      step(3);
      check("prio_mip", mip_o, 32'h0011_0888);
      check("prio_20", {27'd0, irq_id_ctrl_o}, 32'd20);
      mie_i = 32'hFFEE_FFFF; #1;
      check("prio_11", {27'd0, irq_id_ctrl_o}, 32'd11);
      mie_i = 32'hFFEE_F7FF; #1;
      check("prio_3", {27'd0, irq_id_ctrl_o}, 32'd3);
      mie_i = 32'hFFFF_FFFF; irq_i = 32'h0;
      step(3);
      check("prio_clear", mip_o, 32'h0);

      // Edge latch on line 18 and ack
      irq_i = 32'h0004_0000;
      step(1);
      irq_i = 32'h0;
      step(4);
      check("edge_latch", mip_o, 32'h0004_0000);
      check("edge_id", {27'd0, irq_id_ctrl_o}, 32'd18);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd18;
      step(1);
      irq_ack_i = 1'b0; #1;
      check("edge_ack", mip_o, 32'h0);
      step(1);
      irq_i = 32'h0004_0000;
      step(1);
      irq_i = 32'h0;
      step(3);
      check("edge_relatch", mip_o, 32'h0004_0000);
      irq_i = 32'h0004_0000;
      step(1);
      irq_i = 32'h0;
      step(1);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd18;
      step(1);
      irq_ack_i = 1'b0; #1;
      check("edge_set_wins", mip_o, 32'h0004_0000);
      step(1);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd18;
      step(1);
      irq_ack_i = 1'b0; #1;
      check("edge_cleanup", mip_o, 32'h0);

      // Write-clear on edge line 25, ignored on level line 11
      irq_i = 32'h0200_0000;
      step(1);
      irq_i = 32'h0;
      step(3);
      check("wclr_pend", mip_o, 32'h0200_0000);
      mip_clr_i = 32'h0200_0000;
      step(1);
      mip_clr_i = 32'h0; #1;
      check("wclr_mip", mip_o, 32'h0);
      check("wclr_req", {31'd0, irq_req_ctrl_o}, 32'h0);
      irq_i = 32'h800;
      step(3);
      mip_clr_i = 32'h800;
      step(1);
      mip_clr_i = 32'h0; #1;
      check("wclr_level", mip_o, 32'h800);

      // Gating of the request
      mie_i = 32'h800; mstatus_mie_i = 1'b0; #1;
      check("gate_req_mie", {31'd0, irq_req_ctrl_o}, 32'h0);
      check("gate_wu", {31'd0, irq_wu_ctrl_o}, 32'h1);
      check("gate_id", {27'd0, irq_id_ctrl_o}, 32'd11);
      mstatus_mie_i = 1'b1; debug_mode_i = 1'b1; #1;
      check("gate_debug", {31'd0, irq_req_ctrl_o}, 32'h0);
      debug_mode_i = 1'b0; dcsr_step_i = 1'b1; #1;
      check("gate_step", {31'd0, irq_req_ctrl_o}, 32'h0);
      dcsr_stepie_i = 1'b1; #1;
      check("gate_stepie", {31'd0, irq_req_ctrl_o}, 32'h1);
      dcsr_step_i = 1'b0; dcsr_stepie_i = 1'b0;

      // Valid masking and asynchronous reset
      irq_i = 32'hFFFF_FFFF; mie_i = 32'hFFFF_FFFF;
      step(3);
      check("mask_mip", mip_o, 32'hFFFF_0888);
      #1 rst_n = 1'b0; #1;
      check("arst_mip", mip_o, 32'h0);
      check("arst_req", {31'd0, irq_req_ctrl_o}, 32'h0);
      check("arst_id",  {27'd0, irq_id_ctrl_o}, 32'h0);
      check("arst_wu",  {31'd0, irq_wu_ctrl_o}, 32'h0);
      step(1);
      rst_n = 1'b1;
      step(2);
      check("rel_early", mip_o, 32'h0);
      step(1);
      check("rel_mip", mip_o, 32'hFFFF_0888);

      // Randomized traffic against the model
      irq_i = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         rst_n         = ($urandom_range(199) != 0);
         irq_i         = irq_i ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(15) == 0) mie_i = $urandom;
         mstatus_mie_i = ($urandom_range(9) != 0);
         debug_mode_i  = ($urandom_range(19) == 0);
         dcsr_step_i   = ($urandom_range(9) == 0);
         dcsr_stepie_i = $urandom_range(1) == 1;
         mip_clr_i     = ($urandom_range(5) == 0) ? ($urandom & $urandom) : 32'h0;
         #1;
         if (mdl_req() && $urandom_range(1) == 1) begin
            irq_ack_i    = 1'b1;
            irq_ack_id_i = mdl_id();
         end else begin
            irq_ack_i    = 1'b0;
         end
         step(1);
      end
      irq_ack_i = 1'b0;
      rst_n = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cv32e40x_irq_ctrl.md
Name: cv32e40x_irq_ctrl

Overview:
- Upstream interrupt front-end for the controller FSM. It is the sole source of the FSM's irq request, irq id and wake-up inputs.
- Synchronises raw irq lines and latches edge-type lines into pending state. Masks against mie/mstatus.MIE, prioritises, and presents a single request/id.
- Pending edge bits are cleared on the FSM's interrupt-take acknowledge or by a CSR write-clear.
- Supplies mip to the CSR block.

Parameters:
- IRQ_SYNC_STAGES, 2: synchroniser flops per irq line (0 = input already synchronous). Legal range 0..3.
- EDGE_MASK, 32'h0: bit set = line is rising-edge latched; bit clear = level sensitive.
- IRQ_VALID_MASK, 32'hFFFF_0888: implemented lines (3, 7, 11, 16..31). Unimplemented bits read 0 everywhere.

Ports:
- clk  in  1  gated core clock
- rst_n  in  1  asynchronous active-low reset
- irq_i  in  32  raw interrupt lines
- mie_i  in  32  mie CSR value
- mstatus_mie_i  in  1  global machine interrupt enable
- debug_mode_i  in  1  core in debug mode
- dcsr_step_i  in  1  dcsr.step set
- dcsr_stepie_i  in  1  dcsr.stepie set
- irq_ack_i  in  1  FSM takes interrupt this cycle
- irq_ack_id_i  in  5  id being taken
- mip_clr_i  in  32  CSR write-clear of edge-pending bits (one-cycle strobe per bit)
- mip_o  out  32  pending vector to CSR
- irq_req_ctrl_o  out  1  interrupt request to controller FSM
- irq_id_ctrl_o  out  5  highest-priority pending-and-enabled id
- irq_wu_ctrl_o  out  1  wake-up request (for WFI exit)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops reset to 0. All outputs are 0 during and after reset until a line is sampled high.
- Synchroniser: IRQ_SYNC_STAGES flops per line. irq_s = last stage output, or irq_i directly when the parameter is 0.
- Level lines: pend_q[i] <= irq_s[i] every cycle. irq_ack_i and mip_clr_i have no effect on level lines.
- Edge lines:
  - irq_s_q holds the previous irq_s.
  - set[i] = irq_s[i] & ~irq_s_q[i].
  - clr[i] = mip_clr_i[i] | (irq_ack_i & irq_ack_id_i==i).
  - pend_q[i] <= set[i] | (pend_q[i] & ~clr[i]). Set wins over a simultaneous clear.
- Masking: pend_q is ANDed with IRQ_VALID_MASK before any use.
- mip_o = pend_q. It is registered, with no combinational path from irq_i.
- Latency: irq_i high to mip_o high is IRQ_SYNC_STAGES+1 cycles, for both level and edge lines.
- Enabled set: en = mip_o & mie_i.
- irq_wu_ctrl_o = |en, independent of mstatus_mie_i and debug state.
- irq_req_ctrl_o = |en & mstatus_mie_i & ~debug_mode_i & ~(dcsr_step_i & ~dcsr_stepie_i). It is combinational from registered state and CSR inputs.
- irq_id_ctrl_o priority, highest first: 31, 30, ..., 16, then 11 (MEI), 3 (MSI), 7 (MTI).
  - It is 0 when en == 0.
  - It is valid whenever |en, even if irq_req_ctrl_o is suppressed.
- Ack:
  - irq_ack_i is only legal while irq_req_ctrl_o=1 with irq_ack_id_i==irq_id_ctrl_o. A bench assertion flags violations.
  - Ack of a level line is ignored; the source must deassert it.
- Reset mid-operation clears all pending edge state immediately. Edges occurring during reset are lost.
- An irq_i pulse shorter than one clock on an edge line is not guaranteed to be captured.

Test Plan:
- Level MTI: IRQ_SYNC_STAGES=2, mie_i=32'h80, mstatus_mie_i=1. Raise irq_i[7] at cycle 0 → mip_o[7] and irq_req_ctrl_o=1 at cycle 3, irq_id_ctrl_o=7. Drop irq_i[7] → req=0 three cycles later.
- Priority: irq_i bits 3, 7, 11, 16, 20 all high, mie all set → irq_id_ctrl_o=20. Clear mie_i[20] and mie_i[16] → id=11. Then also clear mie_i[11] → id=3.
- Edge latch/ack: EDGE_MASK[18]=1. One-cycle-wide synchronous pulse on irq_i[18] → mip_o[18] stays 1 after the pulse. irq_ack_i with id 18 → mip_o[18]=0 next cycle. New rising edge in the same cycle as the ack → mip_o[18] remains 1.
- Write-clear: edge line 25 pending, mip_clr_i[25]=1 for one cycle → mip_o[25]=0, irq_req_ctrl_o=0. mip_clr_i on level line 11 while irq_i[11]=1 → mip_o[11] stays 1.
- Gating: pending enabled MEI with mstatus_mie_i=0 → irq_req_ctrl_o=0, irq_wu_ctrl_o=1, id=11. Set mstatus_mie_i=1, debug_mode_i=1 → req=0. debug_mode_i=0, dcsr_step_i=1, dcsr_stepie_i=0 → req=0. dcsr_stepie_i=1 → req=1.
- Reset/masking: irq_i=32'hFFFF_FFFF, mie all 1 → mip_o=32'hFFFF_0888. Assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately. Release → mip_o returns after IRQ_SYNC_STAGES+1 cycles.
